// File: rtl/mips_cpu_pkg.sv
// -----------------------------------------------------------------------------
// mips_cpu_pkg
// Shared types and constants for the MIPS CPU bus-side logic.
//   size_t      : access width of a load/store (byte, half, word)
//   state_t     : state encoding of the data-side bus master FSM
//   RESET_VECTOR: boot address of the CPU
// Helpers:
//   decode_size   : maps the raw 2-bit size field to size_t (2'b11 -> word)
//   is_misaligned : natural-alignment check for a given size and addr[1:0]
// -----------------------------------------------------------------------------
package mips_cpu_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      RDWAIT = 3'd2,
      DONE   = 3'd3,
      ERR    = 3'd4
   } state_t;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

   function automatic size_t decode_size(input logic [1:0] raw);
      size_t s;
      case (raw)
         2'b00:   s = SIZE_BYTE;
         2'b01:   s = SIZE_HALF;
         default: s = SIZE_WORD;
      endcase
      return s;
   endfunction

   function automatic logic is_misaligned(input size_t s, input logic [1:0] addr_lo);
      logic bad;
      case (s)
         SIZE_HALF: bad = addr_lo[0];
         SIZE_WORD: bad = (addr_lo != 2'b00);
         default:   bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mips_cpu_lane_align.sv
// -----------------------------------------------------------------------------
// mips_cpu_lane_align
// Purely combinational byte-lane steering between the CPU's right-justified
// data and the 32-bit little-endian memory bus. Shared with the fetch path.
// Ports:
//   size_i       in  access size
//   addr_lo_i    in  byte offset within the word (addr[1:0])
//   sign_i       in  sign-extend byte/half load results
//   wdata_i      in  right-justified store data
//   rdata_i      in  raw bus read data
//   byteenable_o out active byte lanes
//   wdata_o      out store data replicated onto every candidate lane
//   rdata_o      out extracted and extended load result
// -----------------------------------------------------------------------------
module mips_cpu_lane_align
   import mips_cpu_pkg::*;
(
   input  size_t       size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        sign_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  byteenable_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [31:0] lane;

   always_comb begin
      // Move the addressed lane down to bit 0 before extending.
      lane         = rdata_i >> {addr_lo_i, 3'b000};
      byteenable_o = 4'b1111;
      wdata_o      = wdata_i;
      rdata_o      = lane;
      case (size_i)
         SIZE_BYTE: begin
            byteenable_o = 4'b0001 << addr_lo_i;
            wdata_o      = {4{wdata_i[7:0]}};
            rdata_o      = {{24{sign_i & lane[7]}}, lane[7:0]};
         end
         SIZE_HALF: begin
            byteenable_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o      = {2{wdata_i[15:0]}};
            rdata_o      = {{16{sign_i & lane[15]}}, lane[15:0]};
         end
         default: begin
            byteenable_o = 4'b1111;
            wdata_o      = wdata_i;
            rdata_o      = lane;
         end
      endcase
   end

endmodule

// File: rtl/mips_cpu_bus_master.sv
// -----------------------------------------------------------------------------
// mips_cpu_bus_master
// Data-side bus initiator: turns one CPU load/store into one memory-bus
// transaction, honouring waitrequest and a fixed registered read latency.
//
// Bus handshake: a transfer is accepted at the rising edge where read or write
// is high and waitrequest is low; until then every bus output holds steady.
// Reads return readdata READ_LATENCY edges after the acceptance edge.
//
// Parameters:
//   READ_LATENCY   (1..3) acceptance edge to readdata sampling edge
//   TIMEOUT_CYCLES stall limit, only used when MIPS_CPU_BUS_TIMEOUT_EN is defined
// Optional feature macro: MIPS_CPU_BUS_TIMEOUT_EN (waitrequest stall timeout)
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   cpu_req/we/size/signed/addr/wdata  request from datapath (sampled in IDLE)
//   cpu_busy/done/err/rdata            status and load result to datapath
//   address/read/write/writedata/byteenable/waitrequest/readdata  memory bus
//   dbg_state                          current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module mips_cpu_bus_master
   import mips_cpu_pkg::*;
#(
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_size,
   input  logic        cpu_signed,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_busy,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic [31:0] cpu_rdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic [2:0]  dbg_state
);

   localparam logic [1:0] RL_INIT = 2'(READ_LATENCY - 1);

   state_t      state_q;
   logic        we_q;
   size_t       size_q;
   logic        signed_q;
   logic [1:0]  addr_lo_q;
   logic [1:0]  cnt_q;
   logic        read_q;
   logic        write_q;
   logic [31:0] address_q;
   logic [31:0] writedata_q;
   logic [3:0]  be_q;
   logic        done_q;
   logic        err_q;
   logic [31:0] rdata_q;

   // In IDLE the aligner sees the live request so lanes can be registered at
   // the launch edge; afterwards it sees the latched request for extraction.
   size_t       size_d;
   logic [1:0]  addr_lo_d;
   logic        signed_d;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;

   always_comb begin
      size_d    = size_q;
      addr_lo_d = addr_lo_q;
      signed_d  = signed_q;
      if (state_q == IDLE) begin
         size_d    = decode_size(cpu_size);
         addr_lo_d = cpu_addr[1:0];
         signed_d  = cpu_signed;
      end
   end

   mips_cpu_lane_align u_align (
      .size_i       (size_d),
      .addr_lo_i    (addr_lo_d),
      .sign_i       (signed_d),
      .wdata_i      (cpu_wdata),
      .rdata_i      (readdata),
      .byteenable_o (al_be),
      .wdata_o      (al_wdata),
      .rdata_o      (al_rdata)
   );

`ifdef MIPS_CPU_BUS_TIMEOUT_EN
   localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
   logic [STALL_W-1:0] stall_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         size_q      <= SIZE_BYTE;
         signed_q    <= 1'b0;
         addr_lo_q   <= 2'b00;
         cnt_q       <= 2'b00;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         address_q   <= 32'h0;
         writedata_q <= 32'h0;
         be_q        <= 4'h0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= 32'h0;
`ifdef MIPS_CPU_BUS_TIMEOUT_EN
         stall_q     <= '0;
`endif
      end else begin
         // done/err are single-cycle pulses unless re-armed below.
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cpu_req) begin
                  we_q      <= cpu_we;
                  size_q    <= size_d;
                  signed_q  <= cpu_signed;
                  addr_lo_q <= cpu_addr[1:0];
                  if (is_misaligned(size_d, cpu_addr[1:0])) begin
                     state_q <= ERR;
                     err_q   <= 1'b1;
                  end else begin
                     state_q     <= REQ;
                     address_q   <= {cpu_addr[31:2], 2'b00};
                     be_q        <= al_be;
                     writedata_q <= al_wdata;
                     read_q      <= ~cpu_we;
                     write_q     <= cpu_we;
`ifdef MIPS_CPU_BUS_TIMEOUT_EN
                     stall_q     <= '0;
`endif
                  end
               end
            end
            REQ: begin
               if (!waitrequest) begin
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
                  if (we_q) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RDWAIT;
                     cnt_q   <= RL_INIT;
                  end
               end
`ifdef MIPS_CPU_BUS_TIMEOUT_EN
               else if (stall_q == STALL_LAST) begin
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
                  state_q <= ERR;
                  err_q   <= 1'b1;
               end else begin
                  stall_q <= stall_q + 1'b1;
               end
`endif
            end
            RDWAIT: begin
               if (cnt_q == 2'b00) begin
                  rdata_q <= al_rdata;
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE:    state_q <= IDLE;
            ERR:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu_busy   = (state_q != IDLE);
   assign cpu_done   = done_q;
   assign cpu_err    = err_q;
   assign cpu_rdata  = rdata_q;
   assign address    = address_q;
   assign read       = read_q;
   assign write      = write_q;
   assign writedata  = writedata_q;
   assign byteenable = be_q;
   assign dbg_state  = state_q;

endmodule
